// File: rtl/branch_pkg.sv
// Shared definitions for the branch / PC unit: funct3 branch codes, FSM state
// encoding and default reset/trap addresses.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Bundle of fetch handshake, instruction-decode, comparator and status signals
// between the branch/PC unit (master) and its surroundings (slave).
interface branch_pc_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             fetch_req;
  logic             fetch_ack;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [2:0]       funct3;
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic [31:0]      target;
  logic             BrUn;
  logic             BrEq;
  logic             BrLT;
  logic             stall;
  logic             pc_sel;
  logic             retire;
  logic             illegal_br;
  logic             trap;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output fetch_req, pc, pc_plus4, BrUn, pc_sel, retire, illegal_br, trap, retire_cnt,
           taken_cnt,
    input  fetch_ack, funct3, is_branch, is_jal, is_jalr, target, BrEq, BrLT, stall
  );

  modport slave (
    input  fetch_req, pc, pc_plus4, BrUn, pc_sel, retire, illegal_br, trap, retire_cnt,
           taken_cnt,
    output fetch_ack, funct3, is_branch, is_jal, is_jalr, target, BrEq, BrLT, stall
  );
endinterface

// File: rtl/branch_cond.sv
// Branch condition evaluation: maps funct3 plus comparator flags to a
// taken/illegal decision and selects signed/unsigned compare.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       take,
  output logic       illegal,
  output logic       BrUn
);

  // Unsigned compare only for BLTU/BGEU; bit 1 also set for the illegal codes.
  assign BrUn = funct3[1];

  // Decode the condition; 010/011 are reserved and never taken.
  always_comb begin
    take    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  take = BrEq;
      F3_BNE:  take = !BrEq;
      F3_BLT:  take = BrLT;
      F3_BGE:  take = !BrLT;
      F3_BLTU: take = BrLT;
      F3_BGEU: take = !BrLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch/PC unit: fetch sequencing FSM, PC register, next-PC mux and
// retire/taken counters.
// Optional feature: define PC_MISALIGN_TRAP_EN to redirect misaligned control
// transfers to TRAP_VEC with a one-cycle trap pulse.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  branch_pc_unit_if.master   bus
);

  state_e           stateQ, stateD;
  logic [31:0]      pcQ, pcD;
  logic [31:0]      nextPc;
  logic [CNT_W-1:0] retireCntQ, retireCntD;
  logic [CNT_W-1:0] takenCntQ, takenCntD;
  logic             take, illegal, pcSel, retire, trap;

  branch_cond u_cond (
    .funct3  (bus.funct3),
    .BrEq    (bus.BrEq),
    .BrLT    (bus.BrLT),
    .take    (take),
    .illegal (illegal),
    .BrUn    (bus.BrUn)
  );

  // Control-transfer select and target; jal wins over jalr, which wins over branch.
  always_comb begin
    pcSel = bus.is_jal | bus.is_jalr | (bus.is_branch & take);
    if (!pcSel) begin
      nextPc = pcQ + 32'd4;
    end else if (bus.is_jal) begin
      nextPc = bus.target;
    end else if (bus.is_jalr) begin
      nextPc = {bus.target[31:1], 1'b0};
    end else begin
      nextPc = bus.target;
    end
  end

  // FSM next state, retire strobe, trap and PC/counter updates.
  always_comb begin
    stateD     = stateQ;
    retire     = 1'b0;
    pcD        = pcQ;
    retireCntD = retireCntQ;
    takenCntD  = takenCntQ;
    unique case (stateQ)
      ST_BOOT:  stateD = ST_FETCH;
      ST_FETCH: if (bus.fetch_ack) stateD = ST_EXEC;
      ST_EXEC: begin
        if (!bus.stall) begin
          retire = 1'b1;
          stateD = ST_FETCH;
        end
      end
      default:  stateD = ST_BOOT;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    trap = retire & pcSel & (nextPc[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    if (retire) begin
      pcD        = trap ? TRAP_VEC : nextPc;
      retireCntD = retireCntQ + CNT_W'(1);
      if (pcSel) takenCntD = takenCntQ + CNT_W'(1);
    end
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ     <= ST_BOOT;
      pcQ        <= RESET_PC;
      retireCntQ <= '0;
      takenCntQ  <= '0;
    end else begin
      stateQ     <= stateD;
      pcQ        <= pcD;
      retireCntQ <= retireCntD;
      takenCntQ  <= takenCntD;
    end
  end

  assign bus.fetch_req  = (stateQ == ST_FETCH);
  assign bus.pc         = pcQ;
  assign bus.pc_plus4   = pcQ + 32'd4;
  assign bus.pc_sel     = pcSel;
  assign bus.retire     = retire;
  assign bus.trap       = trap;
  assign bus.illegal_br = illegal & bus.is_branch & (stateQ == ST_EXEC);
  assign bus.retire_cnt = retireCntQ;
  assign bus.taken_cnt  = takenCntQ;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: the driver pushes the expected retire
// observation per instruction, the monitor pops and compares on each retire.
module tb_branch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc;
    logic        sel;
    logic        ill;
    logic        brun;
    logic        trap;
    logic [31:0] cntR;
    logic [31:0] cntT;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nErrors = 0;
  int   expR = 0;
  int   expT = 0;
  exp_t sb[$];

  branch_pc_unit_if #(.CNT_W(32)) bus ();

  branch_pc_unit #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC),
    .CNT_W    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every retire against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && bus.retire === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ret_pc", bus.pc, e.pc);
        chk("ret_pc_plus4", bus.pc_plus4, e.pc + 32'd4);
        chk("ret_pc_sel", {31'd0, bus.pc_sel}, {31'd0, e.sel});
        chk("ret_illegal_br", {31'd0, bus.illegal_br}, {31'd0, e.ill});
        chk("ret_BrUn", {31'd0, bus.BrUn}, {31'd0, e.brun});
        chk("ret_trap", {31'd0, bus.trap}, {31'd0, e.trap});
        chk("ret_retire_cnt", bus.retire_cnt, e.cntR);
        chk("ret_taken_cnt", bus.taken_cnt, e.cntT);
      end
    end
  end

  task automatic clearFields();
    bus.is_branch = 1'b0;
    bus.is_jal    = 1'b0;
    bus.is_jalr   = 1'b0;
    bus.funct3    = 3'b000;
    bus.BrEq      = 1'b0;
    bus.BrLT      = 1'b0;
    bus.target    = 32'h0;
  endtask

  task automatic issue(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic eq, input logic lt, input logic [31:0] tgt,
                       input logic [31:0] expPc, input logic expSel, input logic expIll,
                       input logic expBrUn, input logic expTrap, input int stallN);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (bus.fetch_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.fetch_req !== 1'b1) begin
      chk("fetch_req_timeout", {31'd0, bus.fetch_req}, 32'd1);
      return;
    end
    bus.is_branch = br;
    bus.is_jal    = jal;
    bus.is_jalr   = jalr;
    bus.funct3    = f3;
    bus.BrEq      = eq;
    bus.BrLT      = lt;
    bus.target    = tgt;
    bus.fetch_ack = 1'b1;
    e.pc   = expPc;
    e.sel  = expSel;
    e.ill  = expIll;
    e.brun = expBrUn;
    e.trap = expTrap;
    e.cntR = expR;
    e.cntT = expT;
    sb.push_back(e);
    expR++;
    if (expSel) expT++;
    @(posedge clk);
    #1 bus.fetch_ack = 1'b0;
    if (stallN > 0) begin
      bus.stall = 1'b1;
      repeat (stallN) begin
        @(negedge clk);
        chk("stall_retire", {31'd0, bus.retire}, 32'd0);
        chk("stall_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
        chk("stall_pc", bus.pc, expPc);
        chk("stall_pc_sel", {31'd0, bus.pc_sel}, {31'd0, expSel});
        @(posedge clk);
        #1;
      end
      bus.stall = 1'b0;
    end
    @(posedge clk);
    #1 clearFields();
  endtask

  logic [31:0] misPc;
  logic        misTrap;

  initial begin
`ifdef PC_MISALIGN_TRAP_EN
    misPc   = TRAP_VEC;
    misTrap = 1'b1;
`else
    misPc   = 32'h0000_0042;
    misTrap = 1'b0;
`endif
    bus.fetch_ack = 1'b0;
    bus.stall     = 1'b0;
    clearFields();
    repeat (2) @(negedge clk);
    chk("rst_pc", bus.pc, RESET_PC);
    chk("rst_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
    chk("rst_retire", {31'd0, bus.retire}, 32'd0);
    chk("rst_trap", {31'd0, bus.trap}, 32'd0);
    chk("rst_retire_cnt", bus.retire_cnt, 32'd0);
    chk("rst_taken_cnt", bus.taken_cnt, 32'd0);
    rst = 1'b0;
    // T1: sequential instructions
    issue(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h4, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h8, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_retire_cnt", bus.retire_cnt, 32'd3);
    // T2/T3: branch conditions
    issue(1, 0, 0, 3'b000, 1, 0, 32'h40,  32'h00C, 1, 0, 0, 0, 0); // BEQ taken
    issue(1, 0, 0, 3'b000, 0, 0, 32'h80,  32'h040, 0, 0, 0, 0, 0); // BEQ not taken
    issue(1, 0, 0, 3'b110, 0, 1, 32'h100, 32'h044, 1, 0, 1, 0, 0); // BLTU taken
    issue(1, 0, 0, 3'b100, 0, 0, 32'h200, 32'h100, 0, 0, 0, 0, 0); // BLT not taken
    issue(1, 0, 0, 3'b101, 0, 1, 32'h300, 32'h104, 0, 0, 0, 0, 0); // BGE not taken
    issue(1, 0, 0, 3'b011, 1, 1, 32'h400, 32'h108, 0, 1, 1, 0, 0); // illegal
    // T4: jalr clears bit 0, with a 3-cycle stall
    issue(0, 0, 1, 3'b000, 0, 0, 32'h1001, 32'h10C, 1, 0, 0, 0, 3);
    // T6: misaligned taken BNE
    issue(1, 0, 0, 3'b001, 0, 0, 32'h42, 32'h1000, 1, 0, 0, misTrap, 0);
    issue(0, 1, 0, 3'b000, 0, 0, 32'h2000, misPc, 1, 0, 0, 0, 0);
    // T5: ack withheld for 5 cycles
    repeat (5) begin
      @(negedge clk);
      chk("wait_fetch_req", {31'd0, bus.fetch_req}, 32'd1);
      chk("wait_pc", bus.pc, 32'h2000);
    end
    // jal and branch together, then pc wraps past FFFF_FFFC
    issue(1, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFFC, 32'h2000, 1, 0, 0, 0, 0);
    issue(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    issue(0, 1, 0, 3'b000, 0, 0, 32'h500, 32'h0, 1, 0, 0, 0, 0);
    // Reset asserted mid-EXEC
    @(negedge clk);
    chk("pre_rst_fetch_req", {31'd0, bus.fetch_req}, 32'd1);
    bus.fetch_ack = 1'b1;
    @(posedge clk);
    #1 bus.fetch_ack = 1'b0;
    bus.stall = 1'b1;
    @(negedge clk);
    chk("pre_rst_pc", bus.pc, 32'h500);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pc", bus.pc, RESET_PC);
    chk("mid_rst_retire_cnt", bus.retire_cnt, 32'd0);
    chk("mid_rst_taken_cnt", bus.taken_cnt, 32'd0);
    chk("mid_rst_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.stall = 1'b0;
    expR = 0;
    expT = 0;
    issue(0, 0, 0, 3'b000, 0, 0, 32'h0, RESET_PC, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("pc_after_reset_run", bus.pc, RESET_PC + 32'd4);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
